uart_cmd_parser_n: RTL and testbench

//  Parametrised byte-command parser sitting after the UART receiver.

---
 rtl/uart_cmd_pkg.sv | 42 ++++
 rtl/cmd_timeout_ctr.sv | 32 +++
 rtl/uart_cmd_parser_n.sv | 151 +++++++++++++++
 tb/tb_uart_cmd_parser_n.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART byte-command parser.
// Holds the default opcode/value bytes, the FSM encoding and the key mode values.
package uart_cmd_pkg;

    localparam logic [7:0] DEF_KEY_BASE   = 8'hB0;
    localparam logic [7:0] DEF_VAL_ON     = 8'hFF;
    localparam logic [7:0] DEF_VAL_OFF    = 8'h00;
    localparam logic [7:0] DEF_OP_REC_ON  = 8'hAA;
    localparam logic [7:0] DEF_OP_REC_OFF = 8'hBB;
    localparam logic [7:0] DEF_OP_RST_CLR = 8'hCC;
    localparam logic [7:0] DEF_OP_RST_SET = 8'hFF;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_VAL = 1'b1
    } state_e;

    typedef enum logic {
        KEY_EXCLUSIVE   = 1'b0,
        KEY_INDEPENDENT = 1'b1
    } key_mode_e;

    // True when any key id in base..base+n-1 equals one of the opcodes.
    function automatic bit key_collides(
        input logic [7:0] base,
        input int         n,
        input logic [7:0] op0,
        input logic [7:0] op1,
        input logic [7:0] op2,
        input logic [7:0] op3
    );
        logic [7:0] id;
        for (int k = 0; k < n; k++) begin
            id = base + 8'(k);
            if (id == op0 || id == op1 || id == op2 || id == op3) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Saturating cycle counter used to bound the wait for a key value byte.
// expire is a combinational pulse on the enabled cycle where the count sits at TIMEOUT_CYC-1.
module cmd_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam int LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [TW-1:0] LAST = TW'(LAST_I);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {TW{1'b1}})) begin
            count <= count + TW'(1);
        end
    end

    assign expire = enable && (TIMEOUT_CYC != 0) && (count == LAST);

endmodule

// File: rtl/uart_cmd_parser_n.sv
// Byte-command parser after the UART receiver: two-byte key commands and one-byte opcodes
// drive registered key, reconfig and reset outputs with done/error status pulses.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | expecting a key id or a control opcode
//   WAIT_VAL | key id latched, expecting VAL_ON / VAL_OFF (timer running)
module uart_cmd_parser_n
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_KEYS    = 4,
    parameter logic [7:0] KEY_BASE    = DEF_KEY_BASE,
    parameter int         KEY_MODE    = 0,
    parameter logic [7:0] VAL_ON      = DEF_VAL_ON,
    parameter logic [7:0] VAL_OFF     = DEF_VAL_OFF,
    parameter logic [7:0] OP_REC_ON   = DEF_OP_REC_ON,
    parameter logic [7:0] OP_REC_OFF  = DEF_OP_REC_OFF,
    parameter logic [7:0] OP_RST_CLR  = DEF_OP_RST_CLR,
    parameter logic [7:0] OP_RST_SET  = DEF_OP_RST_SET,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_out,
    output logic                reconfig_en,
    output logic                sys_rst,
    output logic                busy,
    output logic                cmd_done,
    output logic                cmd_err
);

    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam key_mode_e MODE = (KEY_MODE != 0) ? KEY_INDEPENDENT : KEY_EXCLUSIVE;
    localparam bit KEYS_COLLIDE = key_collides(KEY_BASE, NUM_KEYS,
                                               OP_REC_ON, OP_REC_OFF, OP_RST_CLR, OP_RST_SET);

    generate
        if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
            $error("uart_cmd_parser_n: NUM_KEYS must be within 1..16");
        end
        if (KEYS_COLLIDE) begin : g_key_collision
            $error("uart_cmd_parser_n: a key id overlaps a control opcode");
        end
    endgenerate

    state_e              state, state_nxt;
    logic [KW-1:0]       key_idx, key_idx_nxt;
    logic [NUM_KEYS-1:0] key_nxt;
    logic                rec_nxt, rst_nxt, done_nxt, err_nxt;
    logic [8:0]          key_off;
    logic                is_key;
    logic                tmo_expire;

    // 9-bit offset keeps the range test correct even when KEY_BASE sits near 8'hFF.
    assign key_off = {1'b0, rx_data} - {1'b0, KEY_BASE};
    assign is_key  = (rx_data >= KEY_BASE) && (key_off < 9'(NUM_KEYS));

    cmd_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == IDLE),
        .enable  ((state == WAIT_VAL) && !rx_valid),
        .expire  (tmo_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            key_idx     <= '0;
            key_out     <= '0;
            reconfig_en <= 1'b0;
            sys_rst     <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_idx     <= key_idx_nxt;
            key_out     <= key_nxt;
            reconfig_en <= rec_nxt;
            sys_rst     <= rst_nxt;
            cmd_done    <= done_nxt;
            cmd_err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        key_idx_nxt = key_idx;
        key_nxt     = key_out;
        rec_nxt     = reconfig_en;
        rst_nxt     = sys_rst;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (is_key) begin
                        key_idx_nxt = key_off[KW-1:0];
                        state_nxt   = WAIT_VAL;
                    end else if (rx_data == OP_REC_ON) begin
                        rec_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end else if (rx_data == OP_REC_OFF) begin
                        rec_nxt  = 1'b0;
                        done_nxt = 1'b1;
                    end else if (rx_data == OP_RST_CLR) begin
                        rst_nxt  = 1'b0;
                        done_nxt = 1'b1;
                    end else if (rx_data == OP_RST_SET) begin
                        rst_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            WAIT_VAL: begin
                if (rx_valid) begin
                    state_nxt = IDLE;
                    if (rx_data == VAL_ON) begin
                        if (MODE == KEY_EXCLUSIVE) begin
                            key_nxt = '0;
                        end
                        key_nxt[key_idx] = 1'b1;
                        done_nxt = 1'b1;
                    end else if (rx_data == VAL_OFF) begin
                        if (MODE == KEY_EXCLUSIVE) begin
                            key_nxt = '0;
                        end else begin
                            key_nxt[key_idx] = 1'b0;
                        end
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (tmo_expire) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT_VAL);

endmodule

// File: tb/tb_uart_cmd_parser_n.sv
// Bench for uart_cmd_parser_n: an exclusive-mode and an independent-mode instance share
// one stimulus stream; checked by a vector table, hand sequences and a random run vs. a model.
module tb_uart_cmd_parser_n;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] key0, key1;
    logic       rec0, rec1, rst0, rst1, busy0, busy1, done0, done1, err0, err1;

    always #5 clk = ~clk;

    uart_cmd_parser_n #(.NUM_KEYS(4), .KEY_MODE(0), .TIMEOUT_CYC(TO)) dut_excl (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .key_out(key0), .reconfig_en(rec0), .sys_rst(rst0), .busy(busy0),
        .cmd_done(done0), .cmd_err(err0));

    uart_cmd_parser_n #(.NUM_KEYS(4), .KEY_MODE(1), .TIMEOUT_CYC(TO)) dut_indep (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .key_out(key1), .reconfig_en(rec1), .sys_rst(rst1), .busy(busy1),
        .cmd_done(done1), .cmd_err(err1));

    int errors = 0;
    int checks = 0;

    // Reference model: a pending key index (-1 when none) and the count of idle cycles waited.
    int         m_pend;
    int         m_waited;
    logic [3:0] m_k0, m_k1;
    bit         m_rec, m_rst, m_done, m_err;

    task automatic model_reset();
        m_pend = -1; m_waited = 0; m_k0 = '0; m_k1 = '0;
        m_rec = 0; m_rst = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        m_done = 0;
        m_err  = 0;
        if (m_pend < 0) begin
            if (v) begin
                if (d >= 8'hB0 && d <= 8'hB3) begin
                    m_pend   = int'(d) - 176;
                    m_waited = 0;
                end else if (d == 8'hAA) begin m_rec = 1; m_done = 1; end
                else if (d == 8'hBB) begin m_rec = 0; m_done = 1; end
                else if (d == 8'hCC) begin m_rst = 0; m_done = 1; end
                else if (d == 8'hFF) begin m_rst = 1; m_done = 1; end
                else m_err = 1;
            end
        end else if (v) begin
            if (d == 8'hFF) begin
                m_k0 = 4'(1 << m_pend);
                m_k1[m_pend] = 1'b1;
                m_done = 1;
            end else if (d == 8'h00) begin
                m_k0 = '0;
                m_k1[m_pend] = 1'b0;
                m_done = 1;
            end else begin
                m_err = 1;
            end
            m_pend = -1;
        end else begin
            m_waited++;
            if (m_waited == TO) begin
                m_err  = 1;
                m_pend = -1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " key_excl"},  key0,  m_k0);
        check({tag, " key_indep"}, key1,  m_k1);
        check({tag, " reconfig"},  {rec1, rec0},  {m_rec, m_rec});
        check({tag, " sys_rst"},   {rst1, rst0},  {m_rst, m_rst});
        check({tag, " busy"},      {busy1, busy0}, {2{m_pend >= 0}});
        check({tag, " cmd_done"},  {done1, done0}, {m_done, m_done});
        check({tag, " cmd_err"},   {err1, err0},   {m_err, m_err});
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
    task automatic drive(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        rx_valid = 1'b0;
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        logic [3:0] k0;
        logic [3:0] k1;
        bit         rec, rst, busy, done, err;
    } vec_t;

    function automatic vec_t mk(bit v, logic [7:0] d, logic [3:0] k0, logic [3:0] k1,
                                bit rec, bit rst, bit busy, bit done, bit err);
        vec_t r;
        r.v = v; r.d = d; r.k0 = k0; r.k1 = k1;
        r.rec = rec; r.rst = rst; r.busy = busy; r.done = done; r.err = err;
        return r;
    endfunction

    vec_t vecs[24];
    logic [3:0] saved0, saved1;

    initial begin
        //              v  data   k_excl   k_indep  rec rst busy done err
        vecs[0]  = mk(1, 8'hB2, 4'b0000, 4'b0000, 0, 0, 1, 0, 0);
        vecs[1]  = mk(1, 8'hFF, 4'b0100, 4'b0100, 0, 0, 0, 1, 0);
        vecs[2]  = mk(1, 8'hB0, 4'b0100, 4'b0100, 0, 0, 1, 0, 0);
        vecs[3]  = mk(1, 8'h00, 4'b0000, 4'b0100, 0, 0, 0, 1, 0);
        vecs[4]  = mk(1, 8'hB2, 4'b0000, 4'b0100, 0, 0, 1, 0, 0);
        vecs[5]  = mk(1, 8'h00, 4'b0000, 4'b0000, 0, 0, 0, 1, 0);
        vecs[6]  = mk(1, 8'hB0, 4'b0000, 4'b0000, 0, 0, 1, 0, 0);
        vecs[7]  = mk(1, 8'hFF, 4'b0001, 4'b0001, 0, 0, 0, 1, 0);
        vecs[8]  = mk(1, 8'hB3, 4'b0001, 4'b0001, 0, 0, 1, 0, 0);
        vecs[9]  = mk(1, 8'hFF, 4'b1000, 4'b1001, 0, 0, 0, 1, 0);
        vecs[10] = mk(1, 8'hB0, 4'b1000, 4'b1001, 0, 0, 1, 0, 0);
        vecs[11] = mk(1, 8'h00, 4'b0000, 4'b1000, 0, 0, 0, 1, 0);
        vecs[12] = mk(1, 8'hAA, 4'b0000, 4'b1000, 1, 0, 0, 1, 0);
        vecs[13] = mk(1, 8'hBB, 4'b0000, 4'b1000, 0, 0, 0, 1, 0);
        vecs[14] = mk(1, 8'hFF, 4'b0000, 4'b1000, 0, 1, 0, 1, 0);
        vecs[15] = mk(1, 8'hCC, 4'b0000, 4'b1000, 0, 0, 0, 1, 0);
        vecs[16] = mk(1, 8'h12, 4'b0000, 4'b1000, 0, 0, 0, 0, 1);
        vecs[17] = mk(0, 8'hFF, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
        vecs[18] = mk(1, 8'hB1, 4'b0000, 4'b1000, 0, 0, 1, 0, 0);
        vecs[19] = mk(1, 8'h55, 4'b0000, 4'b1000, 0, 0, 0, 0, 1);
        vecs[20] = mk(1, 8'hB1, 4'b0000, 4'b1000, 0, 0, 1, 0, 0);
        vecs[21] = mk(1, 8'hB2, 4'b0000, 4'b1000, 0, 0, 0, 0, 1);
        vecs[22] = mk(1, 8'hB1, 4'b0000, 4'b1000, 0, 0, 1, 0, 0);
        vecs[23] = mk(1, 8'hAA, 4'b0000, 4'b1000, 0, 0, 0, 0, 1);

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        #12;
        check("reset key_excl", key0, 4'b0000);
        check("reset key_indep", key1, 4'b0000);
        check("reset flags", {rec0, rst0, busy0, done0, err0, rec1, rst1, busy1, done1, err1}, 10'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d key_excl", i), key0, vecs[i].k0);
            check($sformatf("vec%0d key_indep", i), key1, vecs[i].k1);
            check($sformatf("vec%0d reconfig", i), {rec1, rec0}, {2{vecs[i].rec}});
            check($sformatf("vec%0d sys_rst", i), {rst1, rst0}, {2{vecs[i].rst}});
            check($sformatf("vec%0d busy", i), {busy1, busy0}, {2{vecs[i].busy}});
            check($sformatf("vec%0d cmd_done", i), {done1, done0}, {2{vecs[i].done}});
            check($sformatf("vec%0d cmd_err", i), {err1, err0}, {2{vecs[i].err}});
        end

        // Value timeout: B1 then eight cycles without a byte.
        saved0 = key0;
        saved1 = key1;
        drive(1, 8'hB1);
        for (int i = 0; i < TO - 1; i++) begin
            drive(0, 8'h00);
            check($sformatf("tmo wait%0d busy/err", i), {busy0, busy1, err0, err1}, 4'b1100);
        end
        drive(0, 8'h00);
        check("tmo expiry err/busy", {err0, err1, busy0, busy1, done0}, 5'b11000);
        check("tmo keys kept", {key0, key1}, {saved0, saved1});
        drive(0, 8'h00);
        check("tmo err one pulse", {err0, err1}, 2'b00);

        // A value byte arriving on the expiry cycle wins over the timeout.
        drive(1, 8'hB1);
        for (int i = 0; i < TO - 1; i++) drive(0, 8'h00);
        drive(1, 8'hFF);
        check("late val done/err", {done0, done1, err0, err1, busy0}, 5'b11000);
        check("late val keys", {key0, key1}, 8'b0010_1010);
        check_model("late val");

        // Reset in the middle of a key command.
        drive(1, 8'hAA);
        drive(1, 8'hB3);
        check("pre-reset busy", {busy0, busy1, rec0}, 3'b111);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_model("async reset");
        #1 reset_n = 1'b1;
        drive(1, 8'hFF);
        check("post-reset FF is sys_rst", {rst0, rst1, done0, key0, key1}, {3'b111, 8'h00});
        check_model("post-reset");

        // Random traffic against the model, with occasional long gaps to reach the timeout.
        for (int i = 0; i < 800; i++) begin
            logic [7:0] d;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: d = 8'hB0 + 8'(sel);
                4: d = 8'hFF;
                5: d = 8'h00;
                6: d = 8'hAA;
                7: d = 8'hBB;
                8: d = 8'hCC;
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0) begin
                for (int g = 0; g < TO + 1; g++) begin
                    drive(0, d);
                    check_model($sformatf("rnd%0d gap", i));
                end
            end
            drive($urandom_range(0, 2) != 0, d);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
